fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end with a decoupling instruction queue.
//  Drives a 1-cycle-latency synchronous instruction memory from an internal PC and buffers responses.
//  Hands {pc, pc+4, instr} to decode over a valid/ready handshake; accepts redirects from the branch unit.
//  Adds back-pressure, flush and in-flight kill, which the single-cycle fetch path lacks.
// PARAMETERS
//  AW        64  address/PC width in bits
//  IW        32  instruction width in bits
//  DEPTH     4   queue entries; power of two, >= 2
//  RESET_PC  0   PC value loaded on reset (AW bits)
// PORTS
//  clk             in   1   clock; all state updates on the rising edge
//  reset           in   1   asynchronous, active-high reset
//  imem_req        out  1   fetch request this cycle
//  imem_addr       out  AW  fetch address; equals current PC
//  imem_data       in   IW  instruction for the request made in the previous cycle
//  redirect_valid  in   1   branch/BR/BL resolved: flush and refetch
//  redirect_pc     in   AW  new PC when redirect_valid=1
//  out_valid       out  1   queue head valid
//  out_ready       in   1   decode accepts head
//  out_instr       out  IW  head instruction
//  out_pc          out  AW  head PC
//  out_pc_plus4    out  AW  head PC + 4, for BL link value
//  out_pred_taken  out  1   head was predicted taken (IF_UNCOND_PREDICT_EN only; otherwise 0)
//  q_level         out  $clog2(DEPTH)+1  current queue occupancy
// BEHAVIOUR
//  Reset (async): PC=RESET_PC; queue empty; in-flight=0.
//   Outputs under reset: imem_req=0, out_valid=0, out_pred_taken=0, q_level=0; data outputs 0.
//  Request: imem_req = !reset && !redirect_valid && (q_level + inflight < DEPTH).
//   On a request, PC <= PC+4, modulo 2^AW (wraps silently); inflight <= 1.
//  Response: one cycle after a request, imem_data is written to the tail with its PC.
//   Written only if the request was not killed.
//  Latency: first cycle with reset low issues RESET_PC; out_valid=1 two cycles later.
//   Steady state: one instruction per cycle while out_ready=1.
//  Pop: head leaves when out_valid && out_ready. Push and pop in the same cycle are legal.
//   Credit rule guarantees the queue never overflows.
//  Empty: out_valid=0. Data outputs hold the last head value and must not be relied on.
//   Full: imem_req=0 until a pop.
//  Redirect (priority over everything):
//   - Queue flushed and in-flight response killed.
//   - PC <= redirect_pc; no request in that cycle; a same-cycle pop is ignored.
//   - Request to redirect_pc issued the next cycle.
//  Back-to-back redirects: last one wins. Each redirect kills the prior in-flight response.
//  Reset mid-operation: all state cleared immediately; no partial entry survives.
//  Pointers: $clog2(DEPTH)+1 bits each; the MSB distinguishes full from empty.
// CONFIGURATION
//  IF_UNCOND_PREDICT_EN defined:
//   - A non-killed response with instr[31:26]==6'b000101 (B) is pushed with pred_taken=1.
//   - Same cycle: any request issued is killed; PC <= entryPC + (SignExt(instr[25:0])<<2).
//   - An external redirect in the same cycle overrides the prediction.
//   - BL is not predicted.
//  Undefined: no prediction; out_pred_taken tied 0; B is fetched sequentially like any other instruction.
// STRUCTURE
//  Package if_pkg:
//   - typedef struct fetch_entry_t {pc, instr, pred_taken}
//   - localparam OPC_B = 6'b000101
//   - function br_target(pc, imm26)
//  Sub-module if_queue: synchronous FIFO of fetch_entry_t, DEPTH entries, with a flush input.
//   Exposes count, empty and full.
//  Top level holds the PC register, in-flight/kill flag, credit logic and optional predictor.
// TESTING
//  - Reset release, out_ready=1, imem returns addr-tagged words:
//    out_pc = 0,4,8,12 on consecutive cycles; first out_valid 2 cycles after release.
//  - out_ready=0 for 10 cycles, DEPTH=4: exactly 4 entries queued and imem_req=0.
//    Release: entries drain in order with no loss or duplicate.
//  - redirect_valid with redirect_pc=0x100 while the queue holds 3 entries:
//    out_valid=0 next cycle; next delivered out_pc=0x100; killed response never appears.
//  - Redirect plus pop in the same cycle, then redirect on two consecutive cycles (0x200, 0x300):
//    only 0x300 stream delivered.
//  - AW=8, RESET_PC=8'hF8: PC sequence F8, FC, 00, 04 wraps; out_pc_plus4 of FC = 00.
//  - IF_UNCOND_PREDICT_EN: B with imm26=4 at pc 0x10 -> out_pred_taken=1; next out_pc=0x20.
//    With an external redirect the same cycle, the redirect target wins.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// Package if_pkg
// Shared types and helpers for the instruction-fetch front end.
//   fetch_entry_t : one queued fetch result {pc, instr, pred_taken}. Fields are
//                   sized for the widest supported configuration (AW <= 64,
//                   IW <= 32). Narrower builds zero-extend on entry and
//                   truncate on exit.
//   OPC_B         : opcode of the unconditional PC-relative branch (B).
//   br_target()   : B target = pc + (SignExt(imm26) << 2).
// -----------------------------------------------------------------------------
package if_pkg;

    localparam int MAX_AW = 64;
    localparam int MAX_IW = 32;

    localparam logic [5:0] OPC_B = 6'b000101;

    typedef struct packed {
        logic [MAX_AW-1:0] pc;
        logic [MAX_IW-1:0] instr;
        logic              pred_taken;
    } fetch_entry_t;

    function automatic logic [MAX_AW-1:0] br_target(input logic [MAX_AW-1:0] pc,
                                                    input logic [25:0]       imm26);
        return pc + {{(MAX_AW-28){imm26[25]}}, imm26, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if_queue.sv
// -----------------------------------------------------------------------------
// Module if_queue
// Synchronous FIFO of fetch_entry_t with a single-cycle flush.
// Pointers carry one extra MSB so that full and empty are distinguishable.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (clears pointers and storage)
//   i_flush  in   drop every entry (wins over push and pop)
//   i_push   in   write i_data at the tail (ignored when full)
//   i_data   in   entry to write
//   i_pop    in   advance the head (ignored when empty)
//   o_data   out  head entry (holds its last value while empty)
//   o_count  out  occupancy, 0..DEPTH
//   o_empty  out  no entries
//   o_full   out  DEPTH entries
// -----------------------------------------------------------------------------
module if_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]  r_wr_ptr;
    logic [PW:0]  r_rd_ptr;
    fetch_entry_t r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_mem[r_rd_ptr[PW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer and storage update; flush collapses the tail onto the head so the
    // head slot (and hence o_data) keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= r_rd_ptr;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[PW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// Module fetch_queue
// Instruction-fetch front end: drives a 1-cycle-latency synchronous imem from
// an internal PC, buffers responses in if_queue and hands {pc, pc+4, instr} to
// decode over valid/ready. A redirect flushes the queue, kills the in-flight
// response and restarts fetch at redirect_pc on the following cycle.
// Credit rule: a request is issued only while (occupancy + in-flight) < DEPTH,
// so every response has a free slot and the queue cannot overflow.
// Optional feature (macro IF_UNCOND_PREDICT_EN): an arriving B instruction is
// queued with pred_taken=1 and fetch jumps to its target in the same cycle,
// killing the sequential request issued alongside. Requires IW == 32.
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   imem_req/addr    fetch request and its address (the current PC)
//   imem_data        instruction for last cycle's request
//   redirect_valid   flush and restart at redirect_pc
//   out_valid/ready  decode handshake for the queue head
//   out_instr/pc     head instruction and its PC
//   out_pc_plus4     head PC + 4 (link value)
//   out_pred_taken   head was predicted taken (0 when the feature is off)
//   q_level          queue occupancy
// -----------------------------------------------------------------------------
module fetch_queue
    import if_pkg::*;
#(
    parameter int              AW       = 64,
    parameter int              IW       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [AW-1:0]            imem_addr,
    input  logic [IW-1:0]            imem_data,
    input  logic                     redirect_valid,
    input  logic [AW-1:0]            redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IW-1:0]            out_instr,
    output logic [AW-1:0]            out_pc,
    output logic [AW-1:0]            out_pc_plus4,
    output logic                     out_pred_taken,
    output logic [$clog2(DEPTH):0]   q_level
);

    localparam int              LW      = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0]   PC_STEP = AW'(3'd4);
    localparam logic [LW-1:0]   LIMIT   = LW'(DEPTH);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_req_pc;      // PC of the request whose response is due
    logic          r_inflight;    // a live (not killed) response arrives this cycle

    logic [LW-1:0] w_count;
    logic [LW-1:0] w_used;
    logic          w_empty;
    logic          w_full;
    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic          w_predict;
    logic [AW-1:0] w_br_pc;
    logic          w_unused;
    fetch_entry_t  w_entry;
    fetch_entry_t  w_head;

    // Occupancy plus the outstanding response must leave room for one more.
    assign w_used = w_count + {{(LW-1){1'b0}}, r_inflight};
    assign w_req  = !reset && !redirect_valid && (w_used < LIMIT);
    assign w_push = r_inflight && !redirect_valid;
    assign w_pop  = out_valid && out_ready && !redirect_valid;

`ifdef IF_UNCOND_PREDICT_EN
    logic [MAX_AW-1:0] w_br_full;

    assign w_predict      = w_push && (imem_data[31:26] == OPC_B);
    assign w_br_full      = br_target(MAX_AW'(r_req_pc), imem_data[25:0]);
    assign w_br_pc        = w_br_full[AW-1:0];
    assign out_pred_taken = w_head.pred_taken;
    assign w_unused       = ^{w_head, w_full, w_br_full};
`else
    assign w_predict      = 1'b0;
    assign w_br_pc        = r_pc;
    assign out_pred_taken = 1'b0;
    assign w_unused       = ^{w_head, w_full};
`endif

    // Build the queue entry for the arriving response.
    always_comb begin
        w_entry            = '0;
        w_entry.pc         = MAX_AW'(r_req_pc);
        w_entry.instr      = MAX_IW'(imem_data);
        w_entry.pred_taken = w_predict;
    end

    // PC and in-flight tracking; redirect beats prediction beats sequential fetch.
    // A predicted B leaves the same-cycle request unmarked so its response is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else if (w_predict) begin
            r_pc       <= w_br_pc;
            r_inflight <= 1'b0;
        end else if (w_req) begin
            r_req_pc   <= r_pc;
            r_pc       <= r_pc + PC_STEP;
            r_inflight <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    if_queue #(
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign imem_req     = w_req;
    assign imem_addr    = r_pc;
    assign out_valid    = !w_empty;
    assign out_instr    = w_head.instr[IW-1:0];
    assign out_pc       = w_head.pc[AW-1:0];
    assign out_pc_plus4 = reset ? '0 : (out_pc + PC_STEP);
    assign q_level      = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue. A 64-bit instance (DEPTH=4, RESET_PC=0) is
// exercised through start-up, back-pressure, redirect and reset; an 8-bit
// instance (RESET_PC=F8) checks PC wrap. Memories return address-tagged words
// one cycle after each request. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam logic [31:0] B_INSTR = {6'b000101, 26'd4};

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [63:0] out_pc_plus4;
    logic        out_pred_taken;
    logic [2:0]  q_level;
    logic        b_en = 1'b0;

    logic        imem_req8;
    logic [7:0]  imem_addr8;
    logic [31:0] imem_data8 = 32'h0;
    logic        redirect_valid8 = 1'b0;
    logic [7:0]  redirect_pc8 = 8'h00;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [31:0] out_instr8;
    logic [7:0]  out_pc8;
    logic [7:0]  out_pc_plus4_8;
    logic        out_pred_taken8;
    logic [2:0]  q_level8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_queue #(.AW(64), .IW(32), .DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_pred_taken(out_pred_taken),
        .q_level(q_level)
    );

    fetch_queue #(.AW(8), .IW(32), .DEPTH(4), .RESET_PC(8'hF8)) dut8 (
        .clk(clk), .reset(reset), .imem_req(imem_req8), .imem_addr(imem_addr8),
        .imem_data(imem_data8), .redirect_valid(redirect_valid8), .redirect_pc(redirect_pc8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_instr(out_instr8),
        .out_pc(out_pc8), .out_pc_plus4(out_pc_plus4_8), .out_pred_taken(out_pred_taken8),
        .q_level(q_level8)
    );

    function automatic logic [31:0] tag(input logic [63:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    // Synchronous instruction memories, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_data <= (b_en && imem_addr == 64'h10) ? B_INSTR : tag(imem_addr);
        if (imem_req8) imem_data8 <= {24'hB00000, imem_addr8};
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req",   64'(imem_req),       64'h0);
        chk("rst_valid", 64'(out_valid),      64'h0);
        chk("rst_level", 64'(q_level),        64'h0);
        chk("rst_pred",  64'(out_pred_taken), 64'h0);
        chk("rst_pc",    out_pc,              64'h0);
        chk("rst_p4",    out_pc_plus4,        64'h0);
        chk("rst_valid8", 64'(out_valid8),    64'h0);

        // Start-up: first request is RESET_PC, first out_valid two cycles later
        reset = 1'b0;
        #1;
        chk("n0_req",   64'(imem_req),   64'h1);
        chk("n0_addr",  imem_addr,       64'h0);
        chk("n0_valid", 64'(out_valid),  64'h0);
        chk("n0_addr8", 64'(imem_addr8), 64'hF8);
        @(negedge clk);
        chk("n1_valid", 64'(out_valid),  64'h0);
        chk("n1_addr",  imem_addr,       64'h4);
        chk("n1_addr8", 64'(imem_addr8), 64'hFC);
        @(negedge clk);
        chk("n2_valid", 64'(out_valid),  64'h1);
        chk("n2_pc",    out_pc,          64'h0);
        chk("n2_p4",    out_pc_plus4,    64'h4);
        chk("n2_instr", 64'(out_instr),  64'hA5000000);
        chk("n2_pc8",   64'(out_pc8),    64'hF8);
        @(negedge clk);
        chk("n3_pc",    out_pc,              64'h4);
        chk("n3_pc8",   64'(out_pc8),        64'hFC);
        chk("n3_p4_8",  64'(out_pc_plus4_8), 64'h00);
        @(negedge clk);
        chk("n4_pc",    out_pc,          64'h8);
        chk("n4_pc8",   64'(out_pc8),    64'h00);
        @(negedge clk);
        chk("n5_pc",    out_pc,          64'hC);
        chk("n5_level", 64'(q_level),    64'h1);
        chk("n5_pc8",   64'(out_pc8),    64'h04);

        // Back-pressure: queue fills to DEPTH and requests stop
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("full_level", 64'(q_level),   64'h4);
        chk("full_req",   64'(imem_req),  64'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            chk("drain_valid", 64'(out_valid), 64'h1);
            chk("drain_pc",    out_pc,         64'(12 + 4 * k));
        end

        // Redirect while three entries are queued
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_redir_level", 64'(q_level), 64'h3);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        #1;
        chk("redir_req", 64'(imem_req), 64'h0);
        @(negedge clk);
        chk("redir_valid", 64'(out_valid), 64'h0);
        chk("redir_level", 64'(q_level),   64'h0);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        chk("redir_req_next",  64'(imem_req), 64'h1);
        chk("redir_addr_next", imem_addr,     64'h100);
        @(negedge clk);
        chk("redir_gap", 64'(out_valid), 64'h0);
        @(negedge clk);
        chk("redir_valid2", 64'(out_valid), 64'h1);
        chk("redir_pc",     out_pc,         64'h100);
        chk("redir_instr",  64'(out_instr), 64'hA5000100);

        // Redirect with a same-cycle pop, then back-to-back redirects
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        @(negedge clk);
        chk("b2b_valid", 64'(out_valid), 64'h0);
        chk("b2b_level", 64'(q_level),   64'h0);
        redirect_pc = 64'h300;
        #1;
        chk("b2b_req", 64'(imem_req), 64'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("b2b_req2",  64'(imem_req), 64'h1);
        chk("b2b_addr2", imem_addr,     64'h300);
        @(negedge clk);
        chk("b2b_gap", 64'(out_valid), 64'h0);
        @(negedge clk);
        chk("b2b_valid2", 64'(out_valid), 64'h1);
        chk("b2b_pc",     out_pc,         64'h300);
        chk("b2b_p4",     out_pc_plus4,   64'h304);
        @(negedge clk);
        chk("b2b_pc2", out_pc, 64'h304);

        // Reset mid-operation clears everything immediately
        reset = 1'b1;
        #1;
        chk("mid_rst_level", 64'(q_level),   64'h0);
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_req",   64'(imem_req),  64'h0);
        @(negedge clk);
        reset = 1'b0;

`ifdef IF_UNCOND_PREDICT_EN
        // B at 0x10 with imm26=4 predicted taken to 0x20
        b_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_pc0",   out_pc,              64'h0);
        chk("bp_pred0", 64'(out_pred_taken), 64'h0);
        repeat (4) @(negedge clk);
        chk("bp_pc_b",   out_pc,              64'h10);
        chk("bp_pred_b", 64'(out_pred_taken), 64'h1);
        chk("bp_instr",  64'(out_instr),      64'(B_INSTR));
        @(negedge clk);
        chk("bp_kill", 64'(out_valid), 64'h0);
        @(negedge clk);
        chk("bp_tgt_pc",   out_pc,              64'h20);
        chk("bp_tgt_pred", 64'(out_pred_taken), 64'h0);

        // External redirect in the B response cycle overrides the prediction
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("bpr_pc_c", out_pc, 64'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h400;
        @(negedge clk);
        chk("bpr_valid", 64'(out_valid), 64'h0);
        redirect_valid = 1'b0;
        #1;
        chk("bpr_addr", imem_addr, 64'h400);
        repeat (2) @(negedge clk);
        chk("bpr_pc",   out_pc,              64'h400);
        chk("bpr_pred", 64'(out_pred_taken), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
